// File: rtl/sm_pkg.sv
// Shared sign-magnitude format definitions used by the adder/subtractor and the result decoder.
// A sign-magnitude word is {sign, magnitude}, with the sign in the top bit.
package sm_pkg;

   localparam int SM_W     = 7;
   localparam int SM_MAG_W = SM_W - 1;
   localparam int SIGN_BIT = SM_W - 1;
   localparam int MAG_LSB  = 0;

   // Largest negative value representable in sign-magnitude: {1, all ones}.
   function automatic logic [SM_W-1:0] sm_max_neg();
      logic [SM_W-1:0] v;
      v = '1;
      return v;
   endfunction

endpackage

// File: rtl/sm_neg_stage.sv
// One register stage of the bit-serial two's-complement to magnitude conversion.
// Resolves magnitude bit K: copy up to and including the first 1, invert above it.
module sm_neg_stage
   import sm_pkg::*;
#(
   parameter int W = SM_W,
   parameter int K = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   input  logic         in_neg,
   input  logic [W-2:0] in_raw,
   input  logic [W-2:0] in_mag,
   input  logic         in_seen,
   input  logic         in_zero,
   output logic         out_valid,
   output logic         out_neg,
   output logic [W-2:0] out_raw,
   output logic [W-2:0] out_mag,
   output logic         out_seen,
   output logic         out_zero
);

   logic         valid_q, valid_d;
   logic         neg_q,   neg_d;
   logic [W-2:0] raw_q,   raw_d;
   logic [W-2:0] mag_q,   mag_d;
   logic         seen_q,  seen_d;
   logic         zero_q,  zero_d;

   logic t_k;
   logic m_k;

   assign t_k = in_raw[K];
   assign m_k = t_k ^ (in_neg & in_seen);

   always_comb begin
      valid_d = valid_q;
      neg_d   = neg_q;
      raw_d   = raw_q;
      mag_d   = mag_q;
      seen_d  = seen_q;
      zero_d  = zero_q;
      if (en) begin
         valid_d  = in_valid;
         neg_d    = in_neg;
         raw_d    = in_raw;
         mag_d    = in_mag;
         mag_d[K] = m_k;
         seen_d   = in_seen | t_k;
         zero_d   = in_zero & ~t_k;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         raw_q   <= '0;
         mag_q   <= '0;
         seen_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         neg_q   <= neg_d;
         raw_q   <= raw_d;
         mag_q   <= mag_d;
         seen_q  <= seen_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid = valid_q;
   assign out_neg   = neg_q;
   assign out_raw   = raw_q;
   assign out_mag   = mag_q;
   assign out_seen  = seen_q;
   assign out_zero  = zero_q;

endmodule

// File: rtl/sm_result_decoder.sv
// Pipelined two's-complement to sign-magnitude converter, one magnitude bit per stage,
// valid/ready on both sides with a single global stall.
module sm_result_decoder
   import sm_pkg::*;
#(
   parameter int W = SM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_tc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sm,
   output logic         out_ovf
);

   localparam int D  = W - 1;
   localparam int MW = W - 1;

   logic en;

   // Index 0 is the pipeline input; index gi+1 is the output of stage gi+1.
   logic [D:0]         v_s;
   logic [D:0]         neg_s;
   logic [D:0]         seen_s;
   logic [D:0]         zero_s;
   logic [D:0][MW-1:0] mag_s;
   logic [D-1:0][MW-1:0] raw_s;
   logic [MW-1:0]      raw_unused;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en & rst_n;

   assign v_s[0]    = in_valid;
   assign neg_s[0]  = in_tc[W-1];
   assign raw_s[0]  = in_tc[MW-1:0];
   assign mag_s[0]  = '0;
   assign seen_s[0] = 1'b0;
   assign zero_s[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < D; gi++) begin : g_stage
         logic [MW-1:0] raw_out;

         sm_neg_stage #(
            .W (W),
            .K (gi)
         ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v_s[gi]),
            .in_neg    (neg_s[gi]),
            .in_raw    (raw_s[gi]),
            .in_mag    (mag_s[gi]),
            .in_seen   (seen_s[gi]),
            .in_zero   (zero_s[gi]),
            .out_valid (v_s[gi+1]),
            .out_neg   (neg_s[gi+1]),
            .out_raw   (raw_out),
            .out_mag   (mag_s[gi+1]),
            .out_seen  (seen_s[gi+1]),
            .out_zero  (zero_s[gi+1])
         );

         // The last stage has no further bits to resolve, so its raw copy is dropped.
         if (gi < D - 1) begin : g_fwd
            assign raw_s[gi+1] = raw_out;
         end else begin : g_last
            assign raw_unused = raw_out;
         end
      end
   endgenerate

   assign out_valid = v_s[D];

   // Negative with every magnitude bit zero can only be -2^(W-1): saturate it.
   always_comb begin
      out_ovf = neg_s[D] & zero_s[D];
      out_sm  = {neg_s[D], mag_s[D]};
      if (out_ovf) begin
         out_sm = {1'b1, {MW{1'b1}}};
      end
   end

endmodule

// File: tb/tb_sm_result_decoder.sv
// Directed self-checking bench for sm_result_decoder (W=7).
module tb_sm_result_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_tc;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_sm;
   logic       out_ovf;

   int n_assert = 0;
   int n_fail   = 0;

   logic [6:0] s_tc  [0:7];
   logic [6:0] s_sm  [0:7];
   logic       s_ovf [0:7];

   sm_result_decoder #(.W(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tc     (in_tc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sm    (out_sm),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_single(input string tag, input logic [6:0] tc,
                              input logic [6:0] exp_sm, input logic exp_ovf);
      int cyc;
      in_tc    = tc;
      in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_tc    = '0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, 6);
      check({tag, "_sm"}, out_sm, exp_sm);
      check({tag, "_ovf"}, out_ovf, exp_ovf);
      $display("beat %s: in_tc=%b out_sm=%b out_ovf=%b latency=%0d", tag, tc, out_sm, out_ovf, cyc);
      @(posedge clk); #1;
      check({tag, "_drained"}, out_valid, 0);
   endtask

   task automatic run_stream(input string tag, input int stall_req);
      int  sent, recv, first_acc, last_acc, stall_left;
      bit  stall_done, acc_in, acc_out;
      sent = 0; recv = 0; first_acc = -1; last_acc = -1;
      stall_left = 0; stall_done = 1'b0;
      for (int cyc = 1; cyc <= 60 && recv < 8; cyc++) begin
         if (out_valid && !stall_done && stall_req > 0) begin
            stall_left = stall_req;
            stall_done = 1'b1;
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < 8);
         in_tc     = (sent < 8) ? s_tc[sent] : 7'd0;
         #1;
         if (stall_left > 0) begin
            check({tag, "_stall_in_ready"}, in_ready, 0);
            check({tag, "_stall_hold"}, out_sm, s_sm[recv]);
            stall_left--;
         end
         acc_in  = in_valid & in_ready;
         acc_out = out_valid & out_ready;
         if (acc_out) begin
            check({tag, "_sm"}, out_sm, s_sm[recv]);
            check({tag, "_ovf"}, out_ovf, s_ovf[recv]);
            $display("%s out #%0d: out_sm=%b out_ovf=%b cycle=%0d", tag, recv, out_sm, out_ovf, cyc);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            recv++;
         end
         if (acc_in) sent++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      in_tc     = '0;
      out_ready = 1'b1;
      check({tag, "_count"}, recv, 8);
      check({tag, "_contiguous"}, last_acc - first_acc, 7);
   endtask

   initial begin
      int stale;
      s_tc[0] = 7'b0000111; s_sm[0] = 7'b0000111; s_ovf[0] = 1'b0;
      s_tc[1] = 7'b1110111; s_sm[1] = 7'b1001001; s_ovf[1] = 1'b0;
      s_tc[2] = 7'b1111111; s_sm[2] = 7'b1000001; s_ovf[2] = 1'b0;
      s_tc[3] = 7'b0000000; s_sm[3] = 7'b0000000; s_ovf[3] = 1'b0;
      s_tc[4] = 7'b0111111; s_sm[4] = 7'b0111111; s_ovf[4] = 1'b0;
      s_tc[5] = 7'b1000000; s_sm[5] = 7'b1111111; s_ovf[5] = 1'b1;
      s_tc[6] = 7'b0000001; s_sm[6] = 7'b0000001; s_ovf[6] = 1'b0;
      s_tc[7] = 7'b1100000; s_sm[7] = 7'b1100000; s_ovf[7] = 1'b0;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_tc     = '0;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready_pre", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sm", out_sm, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      send_single("pos7",   7'b0000111, 7'b0000111, 1'b0);
      send_single("neg9",   7'b1110111, 7'b1001001, 1'b0);
      send_single("neg1",   7'b1111111, 7'b1000001, 1'b0);
      send_single("zero",   7'b0000000, 7'b0000000, 1'b0);
      send_single("pos63",  7'b0111111, 7'b0111111, 1'b0);
      send_single("neg64",  7'b1000000, 7'b1111111, 1'b1);

      run_stream("stream", 0);
      run_stream("bp", 5);

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_tc    = s_tc[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_tc    = '0;
      rst_n    = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sm", out_sm, 0);
      check("midrst_out_ovf", out_ovf, 0);
      rst_n = 1'b1;
      stale = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("midrst_stale", stale, 0);
      send_single("rst_neg9", 7'b1110111, 7'b1001001, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
